// File: rtl/cpu_step_controller_if.sv
// Board/CPU side signal bundle for the execution sequencer.
// master drives buttons, breakpoint and CPU state; slave is the sequencer.
interface cpu_step_controller_if;
    logic        step_btn_n;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cpu_en;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] step_count;

    modport master (
        output step_btn_n, run_sw, bp_en, bp_addr, pc, inst,
        input  cpu_en, state, halt_cause, step_count
    );

    modport slave (
        input  step_btn_n, run_sw, bp_en, bp_addr, pc, inst,
        output cpu_en, state, halt_cause, step_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// Execution sequencer: turns a debounced step button or a divided free-run
// rate into one-cycle cpu_en pulses, halting on PC breakpoint or EBREAK.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input logic                  clk,
    input logic                  rst_n,
    cpu_step_controller_if.slave bus
);
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RUN_DIV);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DIV_LAST = RW'(RUN_DIV - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_EBRK = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

    logic [1:0]    btn_sync;
    logic [1:0]    sw_sync;
    logic          btn_s;
    logic          run_s;
    logic          btn_lvl;
    logic [DW-1:0] deb_cnt;
    logic          press;

    state_t        state_q;
    logic [RW-1:0] div_cnt;
    logic          cpu_en_q;
    logic [1:0]    cause_q;
    logic          skip_bp;
    logic [31:0]   count_q;

    logic          is_ebrk;
    logic          is_bp;
    logic          hc;
    logic [1:0]    hc_cause;
    logic          div_tc;

    assign btn_s = btn_sync[1];
    assign run_s = sw_sync[1];

    // EBREAK wins over a breakpoint when both match the same PC.
    assign is_ebrk  = (bus.inst == EBREAK);
    assign is_bp    = bus.bp_en && (bus.pc == bus.bp_addr) && !skip_bp;
    assign hc       = is_ebrk || is_bp;
    assign hc_cause = is_ebrk ? CAUSE_EBRK : CAUSE_BP;
    assign div_tc   = (div_cnt == DIV_LAST);

    // Two-flop synchronizers for the asynchronous button and switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= 2'b11;
            sw_sync  <= 2'b00;
        end else begin
            btn_sync <= {btn_sync[0], bus.step_btn_n};
            sw_sync  <= {sw_sync[0], bus.run_sw};
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES differing samples;
    // press pulses for the one cycle in which the level has just gone low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_lvl <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s == btn_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_lvl <= btn_s;
                deb_cnt <= '0;
                press   <= ~btn_s;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Sequencer FSM with registered cpu_en and halt cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_cnt  <= '0;
            cpu_en_q <= 1'b0;
            cause_q  <= CAUSE_NONE;
            skip_bp  <= 1'b0;
        end else begin
            cpu_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run_s) begin
                        state_q <= RUN;
                        div_cnt <= '0;
                    end else if (press) begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    if (hc) begin
                        state_q <= HALT;
                        cause_q <= hc_cause;
                    end else begin
                        state_q  <= IDLE;
                        cpu_en_q <= 1'b1;
                        skip_bp  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!run_s) begin
                        state_q <= IDLE;
                        div_cnt <= '0;
                    end else if (div_tc) begin
                        div_cnt <= '0;
                        if (hc) begin
                            state_q <= HALT;
                            cause_q <= hc_cause;
                        end else begin
                            cpu_en_q <= 1'b1;
                            skip_bp  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + RW'(1);
                    end
                end
                HALT: begin
                    if (cause_q == CAUSE_BP && press) begin
                        skip_bp <= 1'b1;
                        cause_q <= CAUSE_NONE;
                        state_q <= STEP;
                    end
                end
            endcase
        end
    end

    // Retired-instruction counter, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (cpu_en_q) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.state      = state_q;
    assign bus.halt_cause = cause_q;
    assign bus.step_count = count_q;
endmodule

// File: doc/cpu_step_controller.md
# cpu_step_controller

Execution sequencer for the single-cycle RISC-V CPU. It replaces the raw push-button CPU clock with a single-cycle clock-enable pulse, `cpu_en`, on the system clock. The block debounces the step button, supports single-step and free-run at a divided rate, and halts on a PC breakpoint or on an EBREAK instruction. It sits between the board buttons and switches and the program counter, register file and data memory write enables. It also exports state and a retired-instruction count for the VGA debug view.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a button level (10 ms at 50 MHz).
- `RUN_DIV`, default 25000000: clock cycles per instruction in RUN mode. Legal range is ≥ 4.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `step_btn_n`  in  1  raw step push button, active-low, asynchronous to `clk`.
- `run_sw`  in  1  raw run switch, level-sensitive, asynchronous to `clk`.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  current PC from the program counter.
- `inst`  in  32  instruction at `pc` from instruction memory.
- `cpu_en`  out  1  CPU state-update enable. It is high for exactly one `clk` cycle per executed instruction.
- `state`  out  2  FSM state: 00 IDLE, 01 STEP, 10 RUN, 11 HALT.
- `halt_cause`  out  2  00 none, 01 breakpoint, 10 EBREAK.
- `step_count`  out  32  number of `cpu_en` pulses issued since reset.

## Operation
- **Synchronizers:** `step_btn_n` and `run_sw` each pass through a 2-flop synchronizer before any other use.
- **Debounce (step button):**
  - A counter tracks how long the synchronized button input differs from the debounced level.
  - After `DEBOUNCE_CYCLES` consecutive cycles of difference, the debounced level updates and the counter clears.
  - Any cycle where the input equals the debounced level clears the counter.
  - A press event is a debounced 1→0 transition and lasts one cycle.
- **Halt condition (`hc`), evaluated on the current `pc`/`inst`:**
  - EBREAK when `inst == 32'h00100073`.
  - Breakpoint when `bp_en && pc == bp_addr && !skip_bp`.
  - EBREAK has priority when both are true.
- **IDLE:**
  - Synchronized `run_sw` = 1 → RUN, with the divider cleared.
  - Otherwise, a press event → STEP.
  - `run_sw` has priority over a press in the same cycle.
- **STEP (one cycle):**
  - If `hc` is true → HALT, latch the cause, no pulse.
  - Otherwise → IDLE, schedule `cpu_en`, clear `skip_bp`.
- **RUN:**
  - The divider counts 0..`RUN_DIV`-1 and wraps.
  - At terminal count: if `hc` is true → HALT, latch the cause, no pulse. Otherwise schedule `cpu_en` and clear `skip_bp`.
  - Synchronized `run_sw` = 0 → IDLE immediately, divider cleared, no pulse.
  - Press events are ignored.
- **HALT:**
  - Cause breakpoint: a press event sets `skip_bp` and moves to STEP. That step executes the breakpointed instruction.
  - Cause EBREAK: terminal. Press and `run_sw` are ignored; only reset exits.
  - `halt_cause` clears when HALT is left.
  - Changes to `bp_en`/`bp_addr` while in HALT have no effect until the next `hc` evaluation.
- **Counter:** `step_count` increments on every cycle where `cpu_en` = 1. It wraps 32'hFFFFFFFF → 0.

## Timing
- **Reset values:**
  - `state` = IDLE.
  - `cpu_en` = 0, `halt_cause` = 00, `step_count` = 0, `skip_bp` = 0.
  - Debounced button level = 1, button sync flops = 1, switch sync flops = 0.
  - Debounce and divider counters = 0.
- `cpu_en` is a registered output. It is high in the cycle after the scheduling decision and is never high in two consecutive cycles.
- **Step latency:** press event in cycle N → `state` = STEP in N+1 → `cpu_en` = 1 in N+2, with `state` = IDLE and `step_count` incrementing at the end of N+2.
- **Input stability:** `pc` and `inst` are sampled only in STEP or at the RUN terminal count. The CPU updates them only at the edge that ends a `cpu_en` cycle. `RUN_DIV` ≥ 4 guarantees the next evaluation sees post-update values.
- **Reset mid-operation:** reset asserted in any state, including during a `cpu_en` cycle, forces reset values asynchronously. A pulse interrupted this way is not counted.
- **Input latency:** `run_sw` takes 2 cycles of synchronizer latency plus 1 cycle to change state. Debounce latency is 2 + `DEBOUNCE_CYCLES` cycles.

## Test plan
- **Single step (`DEBOUNCE_CYCLES`=4, `pc`=0, `inst`=NOP):** hold `step_btn_n` low for 10 cycles → exactly one `cpu_en` pulse, `step_count` = 1, `state` returns to 00.
- **Bounce rejection:** toggle `step_btn_n` every 2 cycles for 20 cycles, then release → no `cpu_en`, `step_count` = 0.
- **Free run (`RUN_DIV`=8):** `run_sw` = 1 for 80 cycles → `cpu_en` pulses exactly 8 cycles apart. After `run_sw` = 0, `state` = IDLE within 3 cycles with no further pulses.
- **Breakpoint and resume:**
  - Setup: `bp_en` = 1, `bp_addr` = 0x0C, RUN, `pc` model advancing by 4 per pulse from 0.
  - Expected: halt with `pc` = 0x0C, `halt_cause` = 01, `step_count` = 3.
  - Then press → one pulse, `pc` = 0x10, `halt_cause` = 00, `state` = IDLE, or RUN if `run_sw` is still 1.
- **EBREAK:** in RUN, present `inst` = 32'h00100073 → HALT, `halt_cause` = 10, no pulse. Further presses and `run_sw` toggles produce no pulse. `rst_n` low → all outputs return to reset values.
- **Reset and wrap:**
  - Assert `rst_n` = 0 in the `cpu_en` = 1 cycle → `cpu_en` = 0 immediately, `step_count` = 0.
  - Force `step_count` to 32'hFFFFFFFF and issue one step → `step_count` = 0.
